// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared types and defaults for the two-port RAM arbiter.
//   state_t : arbiter FSM state encoding (IDLE / ACCESS / RDATA)
//   port_t  : requester select encoding (PORT_A = 0, PORT_B = 1)
//   DW_DEF  : default data width
//   AW_DEF  : default address width
package ram_arbiter_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bus bundle between two requesters (A, B) and the RAM arbiter.
//   a_/b_req, we, addr, wdata : request side, driven by the requesters
//   a_/b_gnt, rvalid, rdata   : response side, driven by the arbiter
//   busy                      : arbiter not idle
// Modports: master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          a_req;
    logic          b_req;
    logic          a_we;
    logic          b_we;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] b_wdata;
    logic          a_gnt;
    logic          b_gnt;
    logic          a_rvalid;
    logic          b_rvalid;
    logic [DW-1:0] a_rdata;
    logic [DW-1:0] b_rdata;
    logic          busy;

    modport master (
        output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, busy
    );

    modport slave (
        input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, busy
    );
endinterface

// File: rtl/simple_ram.sv
// simple_ram
// Single-port synchronous RAM, 2**AW words of DW bits, registered read.
//   clk  : clock
//   we   : write enable, din committed to mem[addr] at the rising edge
//   addr : word address
//   din  : write data
//   dout : mem[addr] registered at the rising edge (old data on a write)
// Contents have no reset.
module simple_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Round-robin arbiter giving two requesters access to one simple_ram.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : ram_arbiter_if slave modport (requests in, gnt/rvalid/rdata/busy out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate; latch winner's command, pulse its gnt
// ACCESS | RAM driven with latched command for one cycle
// RDATA  | RAM dout valid; copy to winner's rdata, pulse its rvalid
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    ram_arbiter_if.slave bus
);
    state_t        state;
    port_t         last;
    port_t         sel;
    port_t         win;
    logic          lwe;
    logic [AW-1:0] laddr;
    logic [DW-1:0] lwdata;
    logic [DW-1:0] ram_dout;
    logic          ram_we;
    logic          a_gnt_q, b_gnt_q, a_rvalid_q, b_rvalid_q;
    logic [DW-1:0] a_rdata_q, b_rdata_q;

    // On contention the port that was not served last wins.
    always_comb begin
        win = PORT_A;
        if (bus.a_req && bus.b_req) begin
            win = (last == PORT_A) ? PORT_B : PORT_A;
        end else if (bus.b_req) begin
            win = PORT_B;
        end
    end

    // rst_n gating keeps a reset landing in ACCESS from committing the write.
    assign ram_we = (state == ACCESS) && lwe && rst_n;

    simple_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (laddr),
        .din  (lwdata),
        .dout (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= PORT_B;
            sel        <= PORT_A;
            lwe        <= 1'b0;
            laddr      <= '0;
            lwdata     <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.a_req || bus.b_req) begin
                        sel  <= win;
                        last <= win;
                        if (win == PORT_A) begin
                            lwe     <= bus.a_we;
                            laddr   <= bus.a_addr;
                            lwdata  <= bus.a_wdata;
                            a_gnt_q <= 1'b1;
                        end else begin
                            lwe     <= bus.b_we;
                            laddr   <= bus.b_addr;
                            lwdata  <= bus.b_wdata;
                            b_gnt_q <= 1'b1;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= lwe ? IDLE : RDATA;
                end
                RDATA: begin
                    if (sel == PORT_A) begin
                        a_rdata_q  <= ram_dout;
                        a_rvalid_q <= 1'b1;
                    end else begin
                        b_rdata_q  <= ram_dout;
                        b_rvalid_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_gnt    = a_gnt_q;
    assign bus.b_gnt    = b_gnt_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.busy     = (state != IDLE);
endmodule
